mem_model: RTL and testbench

Behavioural unified instruction/data memory serving the processor core over a single-command memory bus. It holds `MEM_64BIT_LINES` 64-bit lines and accepts at most one load or store per cycle. Each accepted load receives a 4-bit tag, and its data is returned, tagged, a fixed number of cycles later. It sits beside `processor` at the top of the simulation environment; the bench preloads its contents and dumps them after halt.

---
 rtl/mem_model.sv | 136 +++++++++++++
 tb/tb_mem_model.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_model.sv
// ============================================================================
// mem_model : unified memory, one load/store per cycle, tagged fixed-latency loads
// Revision  : 1.0
// ============================================================================
`default_nettype none

module mem_model #(
   parameter int MEM_64BIT_LINES       = 8192,
   parameter int MEM_LATENCY_IN_CYCLES = 10,
   parameter int NUM_MEM_TAGS          = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  proc2mem_command,
   input  logic [31:0] proc2mem_addr,
   input  logic [63:0] proc2mem_data,
   input  logic [1:0]  proc2mem_size,
   output logic [3:0]  mem2proc_response,
   output logic [63:0] mem2proc_data,
   output logic [3:0]  mem2proc_tag
);

   localparam int         IDX_W     = (MEM_64BIT_LINES > 1) ? $clog2(MEM_64BIT_LINES) : 1;
   localparam int         LAT       = MEM_LATENCY_IN_CYCLES;
   localparam logic [1:0] CMD_LOAD  = 2'd1;
   localparam logic [1:0] CMD_STORE = 2'd2;
   localparam logic [1:0] SZ_BYTE   = 2'd0;
   localparam logic [1:0] SZ_HALF   = 2'd1;
   localparam logic [1:0] SZ_WORD   = 2'd2;

   logic [63:0] unified_memory [0:MEM_64BIT_LINES-1];

   logic [28:0]            line_idx;
   logic [2:0]             offset;
   logic [5:0]             bit_shift;
   logic                   in_range;
   logic                   aligned;
   logic                   free_found;
   logic [3:0]             free_tag;
   logic                   load_acc;
   logic                   store_acc;
   logic [63:0]            line_data;
   logic [63:0]            size_mask;
   logic [63:0]            load_field;
   logic [63:0]            store_mask;
   logic [63:0]            store_bits;
   logic [3:0]             done_tag;
   logic [NUM_MEM_TAGS:1]  tag_busy_q;
   logic [NUM_MEM_TAGS:1]  tag_busy_d;
   logic [3:0]             pipe_tag_q  [LAT];
   logic [63:0]            pipe_data_q [LAT];

   assign line_idx  = proc2mem_addr[31:3];
   assign offset    = proc2mem_addr[2:0];
   assign bit_shift = {offset, 3'b000};
   assign in_range  = ({3'b000, line_idx} < 32'(MEM_64BIT_LINES));
   assign line_data = unified_memory[line_idx[IDX_W-1:0]];
   assign done_tag  = pipe_tag_q[LAT-1];

   always_comb begin
      aligned   = 1'b1;
      size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
      case (proc2mem_size)
         SZ_BYTE: size_mask = 64'h0000_0000_0000_00FF;
         SZ_HALF: begin
            size_mask = 64'h0000_0000_0000_FFFF;
            aligned   = (offset[0] == 1'b0);
         end
         SZ_WORD: begin
            size_mask = 64'h0000_0000_FFFF_FFFF;
            aligned   = (offset[1:0] == 2'b00);
         end
         default: aligned = (offset == 3'b000);
      endcase
   end

   // Descending scan so the last hit is the lowest free tag; a store with no free tag still reports 1.
   always_comb begin
      free_found = 1'b0;
      free_tag   = 4'd1;
      for (int t = NUM_MEM_TAGS; t >= 1; t--) begin
         if (!tag_busy_q[t]) begin
            free_found = 1'b1;
            free_tag   = 4'(t);
         end
      end
   end

   assign load_acc  = reset && (proc2mem_command == CMD_LOAD) && in_range && aligned && free_found;
   assign store_acc = reset && (proc2mem_command == CMD_STORE) && in_range && aligned;
   assign mem2proc_response = (load_acc || store_acc) ? free_tag : 4'd0;

   assign load_field = (line_data >> bit_shift) & size_mask;
   assign store_mask = size_mask << bit_shift;
   assign store_bits = (proc2mem_data & size_mask) << bit_shift;

   always_comb begin
      tag_busy_d = tag_busy_q;
      for (int t = 1; t <= NUM_MEM_TAGS; t++) begin
         if (done_tag == 4'(t)) tag_busy_d[t] = 1'b0;
         if (load_acc && (free_tag == 4'(t))) tag_busy_d[t] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tag_busy_q    <= '0;
         mem2proc_tag  <= 4'd0;
         mem2proc_data <= 64'd0;
         for (int i = 0; i < LAT; i++) begin
            pipe_tag_q[i]  <= 4'd0;
            pipe_data_q[i] <= 64'd0;
         end
      end else begin
         tag_busy_q     <= tag_busy_d;
         pipe_tag_q[0]  <= load_acc ? free_tag : 4'd0;
         pipe_data_q[0] <= load_field;
         for (int i = 1; i < LAT; i++) begin
            pipe_tag_q[i]  <= pipe_tag_q[i-1];
            pipe_data_q[i] <= pipe_data_q[i-1];
         end
         mem2proc_tag  <= done_tag;
         mem2proc_data <= (done_tag != 4'd0) ? pipe_data_q[LAT-1] : 64'd0;
      end
   end

   // Storage is deliberately outside the reset domain so it can be preloaded during reset.
   always_ff @(posedge clk) begin
      if (store_acc) begin
         unified_memory[line_idx[IDX_W-1:0]] <= (line_data & ~store_mask) | store_bits;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_model.sv
// ============================================================================
// tb_mem_model : directed + random checks of mem_model against a byte-level model
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_mem_model;

   localparam int         LINES  = 8192;
   localparam int         LAT    = 10;
   localparam logic [1:0] NONE   = 2'd0;
   localparam logic [1:0] LOAD   = 2'd1;
   localparam logic [1:0] STORE  = 2'd2;
   localparam logic [1:0] BYTE   = 2'd0;
   localparam logic [1:0] HALF   = 2'd1;
   localparam logic [1:0] WORD   = 2'd2;
   localparam logic [1:0] DOUBLE = 2'd3;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  cmd   = 2'd0;
   logic [31:0] addr  = 32'd0;
   logic [63:0] wdata = 64'd0;
   logic [1:0]  size  = 2'd0;
   logic [3:0]  resp;
   logic [3:0]  otag;
   logic [63:0] odata;

   logic [1:0]  cmd20  = 2'd0;
   logic [31:0] addr20 = 32'd0;
   logic [63:0] wdata20 = 64'd0;
   logic [1:0]  size20 = 2'd3;
   logic [3:0]  resp20;
   logic [3:0]  tag20;
   logic [63:0] data20;

   mem_model #(.MEM_64BIT_LINES(LINES), .MEM_LATENCY_IN_CYCLES(LAT), .NUM_MEM_TAGS(15)) dut (
      .clk(clk), .reset(reset),
      .proc2mem_command(cmd), .proc2mem_addr(addr), .proc2mem_data(wdata), .proc2mem_size(size),
      .mem2proc_response(resp), .mem2proc_data(odata), .mem2proc_tag(otag)
   );

   mem_model #(.MEM_64BIT_LINES(LINES), .MEM_LATENCY_IN_CYCLES(20), .NUM_MEM_TAGS(15)) dut20 (
      .clk(clk), .reset(reset),
      .proc2mem_command(cmd20), .proc2mem_addr(addr20), .proc2mem_data(wdata20), .proc2mem_size(size20),
      .mem2proc_response(resp20), .mem2proc_data(data20), .mem2proc_tag(tag20)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cycle    = 0;
   bit rst_low  = 1'b0;

   // Reference: byte-addressed memory, tag occupancy and a queue of pending returns.
   logic [7:0] mem_b [LINES*8];
   bit         busy  [16];
   typedef struct {
      int          due;
      logic [3:0]  tag;
      logic [63:0] data;
   } pend_t;
   pend_t pend [$];

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", name, obs, exp);
      end
   endtask

   function automatic logic [63:0] model_line(input int l);
      logic [63:0] v;
      for (int b = 0; b < 8; b++) v[8*b +: 8] = mem_b[l*8 + b];
      return v;
   endfunction

   function automatic logic [3:0] model_resp(input logic [1:0] c, input logic [31:0] a, input logic [1:0] s);
      int nb;
      int lowest;
      nb     = 1 << s;
      lowest = 0;
      for (int t = 15; t >= 1; t--) if (!busy[t]) lowest = t;
      if (rst_low) return 4'd0;
      if (c != LOAD && c != STORE) return 4'd0;
      if ((a >> 3) >= 32'(LINES)) return 4'd0;
      if ((a % 32'(nb)) != 32'd0) return 4'd0;
      if (c == LOAD) return 4'(lowest);
      return (lowest == 0) ? 4'd1 : 4'(lowest);
   endfunction

   task automatic model_edge(input logic [1:0] c, input logic [31:0] a, input logic [63:0] wd,
                             input logic [1:0] s, input logic [3:0] r,
                             output logic [3:0] et, output logic [63:0] ed);
      int          nb;
      int          base;
      logic [63:0] v;
      nb   = 1 << s;
      base = int'(a[15:0]);
      v    = 64'd0;
      et   = 4'd0;
      ed   = 64'd0;
      if (!rst_low && r != 4'd0) begin
         if (c == STORE) begin
            for (int i = 0; i < nb; i++) mem_b[base + i] = wd[8*i +: 8];
         end else begin
            for (int i = 0; i < nb; i++) v[8*i +: 8] = mem_b[base + i];
            busy[r] = 1'b1;
            pend.push_back('{cycle + LAT, r, v});
         end
      end
      if (pend.size() > 0 && pend[0].due == cycle) begin
         et = pend[0].tag;
         ed = pend[0].data;
         busy[et] = 1'b0;
         void'(pend.pop_front());
      end
   endtask

   task automatic step(input logic [1:0] c, input logic [31:0] a, input logic [63:0] wd, input logic [1:0] s,
                       output logic [3:0] r, output logic [3:0] t, output logic [63:0] d);
      logic [3:0]  er;
      logic [3:0]  et;
      logic [63:0] ed;
      cmd = c; addr = a; wdata = wd; size = s;
      #1;
      er = model_resp(c, a, s);
      r  = resp;
      chk("response", 64'(r), 64'(er));
      @(posedge clk);
      cycle++;
      model_edge(c, a, wd, s, er, et, ed);
      #1;
      t = otag;
      d = odata;
      chk("ret_tag", 64'(t), 64'(et));
      if (et != 4'd0) chk("ret_data", d, ed);
   endtask

   task automatic idle(input int n);
      logic [3:0]  r;
      logic [3:0]  t;
      logic [63:0] d;
      for (int i = 0; i < n; i++) step(NONE, 32'd0, 64'd0, BYTE, r, t, d);
   endtask

   task automatic step20(input logic [1:0] c, input logic [31:0] a,
                         output logic [3:0] r, output logic [3:0] t, output logic [63:0] d);
      cmd20 = c; addr20 = a; size20 = DOUBLE;
      #1;
      r = resp20;
      @(posedge clk);
      #1;
      t = tag20;
      d = data20;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0]  r;
      logic [3:0]  t;
      logic [63:0] d;
      logic [63:0] v;

      #3 reset = 1'b0;
      rst_low = 1'b1;
      for (int l = 0; l < LINES; l++) begin
         v = {$urandom, $urandom};
         if (l == 2) v = 64'h1122_3344_5566_7788;
         dut.unified_memory[l] = v;
         for (int b = 0; b < 8; b++) mem_b[l*8 + b] = v[8*b +: 8];
      end
      for (int l = 0; l < 16; l++) dut20.unified_memory[l] = 64'hC0DE_0000_0000_0000 | 64'(l);
      for (int i = 1; i < 16; i++) busy[i] = 1'b0;

      @(posedge clk); #1;
      chk("rst_tag", 64'(otag), 64'd0);
      chk("rst_data", odata, 64'd0);
      step(LOAD, 32'h10, 64'd0, DOUBLE, r, t, d);
      chk("rst_resp", 64'(r), 64'd0);
      step(STORE, 32'h10, 64'hFFFF, HALF, r, t, d);
      reset = 1'b1;
      rst_low = 1'b0;

      // Double load of preloaded line 2
      step(LOAD, 32'h10, 64'd0, DOUBLE, r, t, d);
      chk("t1_resp", 64'(r), 64'd1);
      idle(9);
      step(NONE, 32'd0, 64'd0, BYTE, r, t, d);
      chk("t1_tag", 64'(t), 64'd1);
      chk("t1_data", d, 64'h1122_3344_5566_7788);
      step(NONE, 32'd0, 64'd0, BYTE, r, t, d);
      chk("t1_tag_clear", 64'(t), 64'd0);

      step(LOAD, 32'h13, 64'd0, BYTE, r, t, d);
      chk("byte_resp", 64'(r), 64'd1);
      idle(9);
      step(NONE, 32'd0, 64'd0, BYTE, r, t, d);
      chk("byte_data", d, 64'h0000_0000_0000_0055);
      step(LOAD, 32'h11, 64'd0, HALF, r, t, d);
      chk("misaligned_half", 64'(r), 64'd0);
      step(LOAD, 32'h12, 64'd0, WORD, r, t, d);
      chk("misaligned_word", 64'(r), 64'd0);

      step(STORE, 32'h14, 64'hDEAD_BEEF, WORD, r, t, d);
      chk("store_resp", 64'(r), 64'd1);
      step(LOAD, 32'h10, 64'd0, DOUBLE, r, t, d);
      chk("reload_resp", 64'(r), 64'd1);
      idle(9);
      step(NONE, 32'd0, 64'd0, BYTE, r, t, d);
      chk("merged_data", d, 64'hDEAD_BEEF_5566_7788);

      // Back-to-back loads
      step(LOAD, 32'h00, 64'd0, DOUBLE, r, t, d);
      chk("b2b_resp1", 64'(r), 64'd1);
      step(LOAD, 32'h08, 64'd0, DOUBLE, r, t, d);
      chk("b2b_resp2", 64'(r), 64'd2);
      step(LOAD, 32'h18, 64'd0, DOUBLE, r, t, d);
      chk("b2b_resp3", 64'(r), 64'd3);
      idle(7);
      step(NONE, 32'd0, 64'd0, BYTE, r, t, d);
      chk("b2b_tag1", 64'(t), 64'd1);
      step(NONE, 32'd0, 64'd0, BYTE, r, t, d);
      chk("b2b_tag2", 64'(t), 64'd2);
      step(NONE, 32'd0, 64'd0, BYTE, r, t, d);
      chk("b2b_tag3", 64'(t), 64'd3);

      // Beyond the last line
      step(STORE, 32'(LINES * 8), 64'hFFFF_FFFF_FFFF_FFFF, DOUBLE, r, t, d);
      chk("oob_store", 64'(r), 64'd0);
      step(LOAD, 32'(LINES * 8), 64'd0, DOUBLE, r, t, d);
      chk("oob_load", 64'(r), 64'd0);
      chk("oob_nowrite", dut.unified_memory[0], model_line(0));

      for (int i = 0; i < 400; i++) begin
         logic [1:0]  c;
         logic [1:0]  s;
         logic [31:0] a;
         c = 2'($urandom_range(0, 3));
         s = 2'($urandom_range(0, 3));
         a = 32'($urandom_range(0, 511));
         if ($urandom_range(0, 9) < 7) a = a & ~((32'd1 << s) - 32'd1);
         if ($urandom_range(0, 19) == 0) a = a | 32'h0001_0000;
         step(c, a, {$urandom, $urandom}, s, r, t, d);
      end
      idle(12);

      // Reset with loads in flight
      step(LOAD, 32'h20, 64'd0, DOUBLE, r, t, d);
      idle(7);
      step(LOAD, 32'h28, 64'd0, WORD, r, t, d);
      step(LOAD, 32'h30, 64'd0, HALF, r, t, d);
      step(LOAD, 32'h38, 64'd0, BYTE, r, t, d);
      chk("pre_reset_tag", 64'(t), 64'd1);
      reset = 1'b0;
      rst_low = 1'b1;
      pend.delete();
      for (int i = 1; i < 16; i++) busy[i] = 1'b0;
      #1;
      chk("async_rst_tag", 64'(otag), 64'd0);
      chk("async_rst_data", odata, 64'd0);
      step(LOAD, 32'h40, 64'd0, DOUBLE, r, t, d);
      step(STORE, 32'h40, 64'h1234, WORD, r, t, d);
      reset = 1'b1;
      rst_low = 1'b0;
      idle(25);
      for (int l = 0; l < 64; l++) chk("mem_line", dut.unified_memory[l], model_line(l));

      // Latency 20: tag exhaustion and reuse
      for (int i = 0; i < 16; i++) begin
         step20(LOAD, 32'(i * 8), r, t, d);
         chk("lat20_resp", 64'(r), (i < 15) ? 64'(i + 1) : 64'd0);
         chk("lat20_quiet", 64'(t), 64'd0);
      end
      for (int k = 0; k < 4; k++) begin
         step20(NONE, 32'd0, r, t, d);
         chk("lat20_wait", 64'(t), 64'd0);
      end
      step20(NONE, 32'd0, r, t, d);
      chk("lat20_tag1", 64'(t), 64'd1);
      chk("lat20_data1", d, 64'hC0DE_0000_0000_0000);
      step20(LOAD, 32'h8, r, t, d);
      chk("lat20_reuse", 64'(r), 64'd1);
      chk("lat20_tag2", 64'(t), 64'd2);
      chk("lat20_data2", d, 64'hC0DE_0000_0000_0001);
      step20(NONE, 32'd0, r, t, d);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
